// File: rtl/unit_pool_arbiter.sv
// unit_pool_arbiter
// Round-robin arbiter that feeds four requesters into a pool of two shared
// execution-unit slots. Each slot holds an operand for HOLD cycles, captures
// the unit result, and presents it as a response. Responses from the two
// slots are arbitrated with a one-bit round-robin register. Once a response
// is shown and stalled, the same slot stays presented until it is accepted.

module unit_pool_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int HOLD  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   io_req_valid,
    output logic [N_REQ-1:0]   io_req_ready,
    input  logic [N_REQ*W-1:0] io_req_data,
    output logic [2*W-1:0]     io_unit_in,
    input  logic [2*W-1:0]     io_unit_out,
    output logic               io_resp_valid,
    input  logic               io_resp_ready,
    output logic [W-1:0]       io_resp_data,
    output logic [1:0]         io_resp_src,
    output logic               io_resp_unit
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter reload value: a slot spends HOLD-1 decrement cycles plus one
    // capture cycle in BUSY.
    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    // Per-slot state
    logic [1:0]   state_r   [0:1];
    logic [W-1:0] operand_r [0:1];
    logic [1:0]   src_r     [0:1];
    logic [3:0]   cnt_r     [0:1];
    logic [W-1:0] result_r  [0:1];

    // Arbitration state
    logic [1:0] rr_ptr_r;
    logic       resp_rr_r;
    logic       lock_r;
    logic       lock_sel_r;

    // Combinational decode
    logic [1:0]   slot_idle_s;
    logic [1:0]   slot_done_s;
    logic         win_found_s;
    logic [1:0]   winner_s;
    logic         grant_s;
    logic         slot_sel_s;
    logic [W-1:0] win_data_s;
    logic         resp_sel_s;
    logic         resp_valid_s;
    logic         resp_fire_s;

    // Request arbitration: round-robin search from rr_ptr, lowest idle slot wins
    always_comb begin
        win_found_s    = 1'b0;
        winner_s       = 2'd0;
        slot_idle_s[0] = (state_r[0] == ST_IDLE);
        slot_idle_s[1] = (state_r[1] == ST_IDLE);
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found_s && io_req_valid[rr_ptr_r + 2'(i)]) begin
                win_found_s = 1'b1;
                winner_s    = rr_ptr_r + 2'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
        grant_s    = win_found_s & (|slot_idle_s);
        slot_sel_s = slot_idle_s[0] ? 1'b0 : 1'b1;
        win_data_s = io_req_data[int'(winner_s)*W +: W];
        if (grant_s) begin
            io_req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            io_req_ready = {N_REQ{1'b0}};
        end
    end

    // Response selection: a stalled response keeps its slot; otherwise the
    // single DONE slot, or resp_rr when both are DONE
    always_comb begin
        slot_done_s[0] = (state_r[0] == ST_DONE);
        slot_done_s[1] = (state_r[1] == ST_DONE);
        if (lock_r) begin
            resp_sel_s = lock_sel_r;
        end else if (slot_done_s[0] && slot_done_s[1]) begin
            resp_sel_s = resp_rr_r;
        end else if (slot_done_s[1]) begin
            resp_sel_s = 1'b1;
        end else begin
            resp_sel_s = 1'b0;
        end
        resp_valid_s = |slot_done_s;
        resp_fire_s  = resp_valid_s & io_resp_ready;
    end

    // Slot FSMs: capture on grant, count down while BUSY, release on response
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                state_r[k]   <= ST_IDLE;
                operand_r[k] <= {W{1'b0}};
                src_r[k]     <= 2'd0;
                cnt_r[k]     <= 4'd0;
                result_r[k]  <= {W{1'b0}};
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (state_r[k])
                    ST_IDLE: begin
                        if (grant_s && (slot_sel_s == k[0])) begin
                            operand_r[k] <= win_data_s;
                            src_r[k]     <= winner_s;
                            cnt_r[k]     <= HOLD_M1;
                            state_r[k]   <= ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (cnt_r[k] != 4'd0) begin
                            cnt_r[k] <= cnt_r[k] - 4'd1;
                        end else begin
                            result_r[k] <= io_unit_out[k*W +: W];
                            state_r[k]  <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (resp_fire_s && (resp_sel_s == k[0])) begin
                            state_r[k] <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r[k] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Request pointer advances past the winner on every grant
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= 2'd0;
        end else if (grant_s) begin
            rr_ptr_r <= winner_s + 2'd1;
        end
    end

    // Response round-robin toggle and stall lock
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rr_r  <= 1'b0;
            lock_r     <= 1'b0;
            lock_sel_r <= 1'b0;
        end else if (resp_fire_s) begin
            resp_rr_r <= ~resp_rr_r;
            lock_r    <= 1'b0;
        end else if (resp_valid_s) begin
            lock_r     <= 1'b1;
            lock_sel_r <= resp_sel_s;
        end
    end

    assign io_unit_in    = {operand_r[1], operand_r[0]};
    assign io_resp_valid = resp_valid_s;
    assign io_resp_data  = result_r[resp_sel_s];
    assign io_resp_src   = src_r[resp_sel_s];
    assign io_resp_unit  = resp_sel_s;

endmodule

// File: tb/tb_unit_pool_arbiter.sv
// Testbench for unit_pool_arbiter: two instances (HOLD=3 and HOLD=1) share
// stimulus; a timing-level model predicts every output each cycle, and
// directed literal checks pin the scenarios.

module tb_unit_pool_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        resp_ready;
    logic        unit_mode;

    logic [3:0]  rdy [2];
    logic [15:0] uin [2];
    logic [15:0] uout[2];
    logic        rv  [2];
    logic [7:0]  rd  [2];
    logic [1:0]  rs  [2];
    logic        ru  [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Shared-unit behaviour: identity, or a per-unit transform
    function automatic logic [7:0] ufn(logic [7:0] x, int k, logic mode);
        if (!mode) return x;
        return (k == 0) ? (x ^ 8'hA5) : (x + 8'h11);
    endfunction

    assign uout[0] = {ufn(uin[0][15:8], 1, unit_mode), ufn(uin[0][7:0], 0, unit_mode)};
    assign uout[1] = {ufn(uin[1][15:8], 1, unit_mode), ufn(uin[1][7:0], 0, unit_mode)};

    unit_pool_arbiter #(.N_REQ(4), .W(8), .HOLD(3)) dut_a (
        .clk(clk), .reset(reset),
        .io_req_valid(req_valid), .io_req_ready(rdy[0]), .io_req_data(req_data),
        .io_unit_in(uin[0]), .io_unit_out(uout[0]),
        .io_resp_valid(rv[0]), .io_resp_ready(resp_ready),
        .io_resp_data(rd[0]), .io_resp_src(rs[0]), .io_resp_unit(ru[0])
    );

    unit_pool_arbiter #(.N_REQ(4), .W(8), .HOLD(1)) dut_b (
        .clk(clk), .reset(reset),
        .io_req_valid(req_valid), .io_req_ready(rdy[1]), .io_req_data(req_data),
        .io_unit_in(uin[1]), .io_unit_out(uout[1]),
        .io_resp_valid(rv[1]), .io_resp_ready(resp_ready),
        .io_resp_data(rd[1]), .io_resp_src(rs[1]), .io_resp_unit(ru[1])
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A slot is either free or holds an operation that becomes a visible
    // result at a known cycle number.
    bit         model_ok = 1'b0;
    int         cyc = 0;
    bit         m_occ     [2][2];
    int         m_done_at [2][2];
    logic [7:0] m_op      [2][2];
    logic [1:0] m_src     [2][2];
    int         m_rr      [2];
    bit         m_resp_rr [2];
    bit         m_lock    [2];
    bit         m_lock_sel[2];

    function automatic int hold_of(int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic bit m_done(int d, int k);
        return m_occ[d][k] && (cyc >= m_done_at[d][k]);
    endfunction

    function automatic int m_winner(int d);
        if (m_occ[d][0] && m_occ[d][1]) return -1;
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = (m_rr[d] + i) % 4;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int m_sel(int d);
        if (m_lock[d]) return int'(m_lock_sel[d]);
        if (m_done(d, 0) && m_done(d, 1)) return int'(m_resp_rr[d]);
        if (m_done(d, 1)) return 1;
        return 0;
    endfunction

    task automatic model_step(int d);
        int w, s, k;
        bit v;
        if (reset) begin
            for (int j = 0; j < 2; j++) begin
                m_occ[d][j] = 1'b0;
                m_op[d][j]  = 8'h00;
                m_src[d][j] = 2'd0;
            end
            m_rr[d] = 0; m_resp_rr[d] = 1'b0; m_lock[d] = 1'b0; m_lock_sel[d] = 1'b0;
        end else begin
            w = m_winner(d);
            s = m_sel(d);
            v = m_done(d, 0) | m_done(d, 1);
            if (w >= 0) begin
                k = m_occ[d][0] ? 1 : 0;
                m_occ[d][k]     = 1'b1;
                m_done_at[d][k] = cyc + 1 + hold_of(d);
                m_op[d][k]      = req_data[w*8 +: 8];
                m_src[d][k]     = 2'(w);
                m_rr[d]         = (w + 1) % 4;
            end
            if (v && resp_ready) begin
                m_occ[d][s]  = 1'b0;
                m_resp_rr[d] = ~m_resp_rr[d];
                m_lock[d]    = 1'b0;
            end else if (v) begin
                m_lock[d]     = 1'b1;
                m_lock_sel[d] = s[0];
            end
        end
    endtask

    // Model advances on each rising edge using the inputs held across it
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (reset) model_ok <= 1'b1;
        cyc++;
    end

    // Per-cycle comparison of both instances against the model
    bit log_en = 1'b0;
    int grant_log[$];
    always @(negedge clk) begin
        if (model_ok) begin
            for (int d = 0; d < 2; d++) begin
                int w, s;
                logic [3:0] er;
                bit ev;
                w = m_winner(d);
                er = 4'd0;
                if (w >= 0) er[w] = 1'b1;
                chk($sformatf("d%0d_req_ready", d), rdy[d], er);
                ev = m_done(d, 0) | m_done(d, 1);
                chk($sformatf("d%0d_resp_valid", d), rv[d], ev);
                if (ev) begin
                    s = m_sel(d);
                    chk($sformatf("d%0d_resp_unit", d), ru[d], s);
                    chk($sformatf("d%0d_resp_src", d), rs[d], m_src[d][s]);
                    chk($sformatf("d%0d_resp_data", d), rd[d], ufn(m_op[d][s], s, unit_mode));
                end
                for (int k = 0; k < 2; k++) begin
                    if (m_occ[d][k]) chk($sformatf("d%0d_unit_in%0d", d, k), uin[d][k*8 +: 8], m_op[d][k]);
                end
            end
            if (log_en) begin
                for (int r = 0; r < 4; r++) begin
                    if (rdy[0][r]) grant_log.push_back(r);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_zero(string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_ready0", tag, d), rdy[d], 32'h0);
            chk($sformatf("%s_d%0d_valid0", tag, d), rv[d], 32'h0);
            chk($sformatf("%s_d%0d_data0", tag, d), rd[d], 32'h0);
            chk($sformatf("%s_d%0d_src0", tag, d), rs[d], 32'h0);
            chk($sformatf("%s_d%0d_unit0", tag, d), ru[d], 32'h0);
            chk($sformatf("%s_d%0d_unitin0", tag, d), uin[d], 32'h0);
        end
    endtask

    task automatic do_reset(string tag);
        reset = 1'b1;
        req_valid = 4'd0;
        tick();
        #1;
        lit_zero(tag);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int exp_order [5];
        int seen;
        reset = 1'b1; req_valid = 4'd0; req_data = 32'd0; resp_ready = 1'b0; unit_mode = 1'b0;
        tick();
        do_reset("rst");

        // Single request, identity unit
        resp_ready = 1'b1;
        req_valid = 4'b0001; req_data = 32'h0000_005A;
        #1;
        chk("single_ready_a", rdy[0], 32'h1);
        chk("single_ready_b", rdy[1], 32'h1);
        tick();
        req_valid = 4'd0;
        #1;
        chk("single_unitin_a", uin[0][7:0], 32'h5A);
        chk("single_a_notyet1", rv[0], 32'h0);
        tick(); #1;
        chk("single_b_valid", rv[1], 32'h1);
        chk("single_b_data", rd[1], 32'h5A);
        chk("single_b_src", rs[1], 32'h0);
        chk("single_b_unit", ru[1], 32'h0);
        chk("single_a_notyet2", rv[0], 32'h0);
        tick(); #1;
        chk("single_a_notyet3", rv[0], 32'h0);
        tick(); #1;
        chk("single_a_valid", rv[0], 32'h1);
        chk("single_a_data", rd[0], 32'h5A);
        chk("single_a_src", rs[0], 32'h0);
        chk("single_a_unit", ru[0], 32'h0);
        tick(); #1;
        chk("single_a_gone", rv[0], 32'h0);

        // Fairness: all requesters valid continuously
        do_reset("rst_fair");
        unit_mode = 1'b1; resp_ready = 1'b1;
        req_data = 32'h4433_2211; req_valid = 4'b1111;
        log_en = 1'b1;
        repeat (30) tick();
        log_en = 1'b0;
        req_valid = 4'd0;
        repeat (6) tick();
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
        chk("fair_count_ge5", (grant_log.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            chk($sformatf("fair_order%0d", i), grant_log[i], exp_order[i]);
        end
        for (int r = 0; r < 4; r++) begin
            seen = 0;
            foreach (grant_log[i]) if (grant_log[i] == r) seen++;
            chk($sformatf("fair_served%0d", r), (seen > 0) ? 32'd1 : 32'd0, 32'd1);
        end

        // Backpressure with both slots DONE
        do_reset("rst_bp");
        unit_mode = 1'b1; resp_ready = 1'b0;
        req_data = 32'h0000_3CC3;
        req_valid = 4'b0001; tick();
        req_valid = 4'b0010; tick();
        req_valid = 4'b1111;
        #1;
        chk("bp_ready_a_full", rdy[0], 32'h0);
        chk("bp_ready_b_full", rdy[1], 32'h0);
        repeat (4) tick();
        #1;
        for (int rep = 0; rep < 2; rep++) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("bp_d%0d_ready_r%0d", d, rep), rdy[d], 32'h0);
                chk($sformatf("bp_d%0d_valid_r%0d", d, rep), rv[d], 32'h1);
                chk($sformatf("bp_d%0d_unit_r%0d", d, rep), ru[d], 32'h0);
                chk($sformatf("bp_d%0d_data_r%0d", d, rep), rd[d], 32'h66);
            end
            tick(); #1;
        end
        req_valid = 4'd0; resp_ready = 1'b1;
        #1;
        chk("bp_first_unit", ru[0], 32'h0);
        tick(); #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("bp_d%0d_second_valid", d), rv[d], 32'h1);
            chk($sformatf("bp_d%0d_second_unit", d), ru[d], 32'h1);
            chk($sformatf("bp_d%0d_second_src", d), rs[d], 32'h1);
            chk($sformatf("bp_d%0d_second_data", d), rd[d], 32'h4D);
        end
        tick(); #1;
        chk("bp_drained_a", rv[0], 32'h0);

        // Back-to-back completion with HOLD=1
        do_reset("rst_h1");
        unit_mode = 1'b1; resp_ready = 1'b1;
        req_data = 32'h0000_0201;
        req_valid = 4'b0001; tick();
        req_valid = 4'b0010; tick();
        req_valid = 4'd0;
        #1;
        chk("h1_first_valid", rv[1], 32'h1);
        chk("h1_first_unit", ru[1], 32'h0);
        chk("h1_first_src", rs[1], 32'h0);
        chk("h1_first_data", rd[1], 32'hA4);
        tick(); #1;
        chk("h1_second_valid", rv[1], 32'h1);
        chk("h1_second_unit", ru[1], 32'h1);
        chk("h1_second_src", rs[1], 32'h1);
        chk("h1_second_data", rd[1], 32'h13);
        tick(); #1;
        chk("h1_drained", rv[1], 32'h0);
        repeat (5) tick();

        // Reset while slot0 BUSY and slot1 DONE
        do_reset("rst_mid0");
        unit_mode = 1'b1; resp_ready = 1'b0;
        req_data = 32'h7766_5544;
        req_valid = 4'b0001; tick();
        req_valid = 4'b0010; tick();
        req_valid = 4'd0;
        repeat (3) tick();
        resp_ready = 1'b1; tick();
        resp_ready = 1'b0; req_valid = 4'b0100; tick();
        req_valid = 4'd0;
        #1;
        chk("mid_pre_valid", rv[0], 32'h1);
        chk("mid_pre_unit", ru[0], 32'h1);
        chk("mid_pre_slot0_op", uin[0][7:0], 32'h66);
        do_reset("rst_mid");
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk($sformatf("mid_no_stale_a%0d", i), rv[0], 32'h0);
            chk($sformatf("mid_no_stale_b%0d", i), rv[1], 32'h0);
        end
        req_data = 32'hDDCC_BBAA; req_valid = 4'b1111;
        #1;
        chk("mid_next_ready", rdy[0], 32'h1);
        tick();
        req_valid = 4'd0;
        #1;
        chk("mid_next_slot0", uin[0][7:0], 32'hAA);
        chk("mid_next_slot1_clear", uin[0][15:8], 32'h00);
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/unit_pool_arbiter.md
UNIT_POOL_ARBITER -- requirements
Module: unit_pool_arbiter

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- N_REQ, 4, number of requesters (fixed at 4; the requester ID is 2 bits).
- W, 8, data width.
- HOLD, 3, number of cycles a shared unit slot is occupied per operation (legal range 1..15).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high.
- io_req_valid, in, N_REQ, per-requester request valid.
- io_req_ready, out, N_REQ, per-requester accept.
- io_req_data, in, N_REQ*W, requester i occupies bits [i*W+W-1 : i*W].
- io_unit_in, out, 2*W, operand to shared unit k at bits [k*W+W-1 : k*W].
- io_unit_out, in, 2*W, combinational result from shared unit k.
- io_resp_valid, out, 1, response available.
- io_resp_ready, in, 1, downstream accepts the response.
- io_resp_data, out, W, result data.
- io_resp_src, out, 2, originating requester ID.
- io_resp_unit, out, 1, slot that produced the response.

Function
REQ-003 Each of the two unit slots SHALL run an FSM with states IDLE, BUSY and DONE, and hold these registers: operand, source ID, down-counter (4 bits) and result.

REQ-004 Grant rules:
- At most one grant per cycle.
- A grant is made only when at least one slot is IDLE.
- The winner is the first requester with valid=1, searching from rr_ptr upward modulo N_REQ.
- The winner is assigned to the lowest-numbered IDLE slot.

REQ-005 io_req_ready[i] SHALL be 1 only for the granted requester. It is combinational from io_req_valid and the slot states. A transfer fires when valid&ready.

REQ-006 On fire, the assigned slot SHALL take these actions and the pointer SHALL advance:
- The slot captures the data and the requester ID.
- The slot loads its counter with HOLD-1 and enters BUSY.
- rr_ptr <= (winner+1) mod N_REQ.
- With no fire, rr_ptr holds.

REQ-007 io_unit_in[k] SHALL be driven from slot k's operand register. It holds its value from the cycle after fire until the slot returns to IDLE.

REQ-008 BUSY behaviour:
- When the counter is nonzero, it decrements each cycle.
- When the counter is 0, the slot captures io_unit_out[k] into its result register and enters DONE.
- A fire at edge t SHALL therefore produce DONE, and io_resp_valid=1, after edge t+HOLD.
- With HOLD=1, DONE follows the cycle after fire.

REQ-009 Response selection:
- If exactly one slot is DONE, it is presented.
- If both are DONE, the slot named by the 1-bit resp_rr register is presented.
- resp_rr toggles on every response fire.

REQ-010 io_resp_data, io_resp_src and io_resp_unit SHALL reflect the presented slot's registers, and stay stable while io_resp_valid=1 and io_resp_ready=0.

REQ-011 On response fire (valid&ready), the presented slot SHALL return to IDLE at the next edge. It SHALL NOT be granted in the same cycle as its response fires; it is grantable from the following cycle.

REQ-012 When both slots are BUSY or DONE, all io_req_ready bits SHALL be 0 and rr_ptr SHALL hold.

REQ-013 Requesters MAY drop valid without being granted. The arbiter SHALL keep no lock, and a dropped request SHALL consume no slot.

REQ-014 Both slots MAY complete in the same cycle. Each SHALL enter DONE independently, and no result SHALL be lost or overwritten.

Reset
REQ-015 While reset=1 at a rising edge, the block SHALL set:
- Both slots to IDLE.
- rr_ptr=0 and resp_rr=0.
- All slot registers to 0.

Consequently the outputs SHALL be io_req_ready=0, io_resp_valid=0, io_resp_data=0, io_resp_src=0, io_resp_unit=0 and io_unit_in=0.

REQ-016 A reset asserted mid-operation SHALL discard all in-flight and DONE results. No response for them SHALL appear after reset deasserts.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Single request: HOLD=3, unit = identity, req0 valid with data 0x5A at cycle 0 -> ready0=1 at cycle 0; resp_valid=1 at cycle 3 with data 0x5A, src=0, unit=0.
- Fairness: all four valid continuously, resp_ready=1 -> grant order 0,1,2,3,0 with no requester starved; no new grant while both slots are occupied.
- Backpressure: resp_ready=0 with both slots DONE -> resp_valid stays 1 and data stays stable; all req_ready=0; after ready returns, slots are served in resp_rr order 0 then 1.
- Simultaneous completion: grants on consecutive cycles with HOLD=1 -> two responses on consecutive cycles and none lost.
- Reset mid-operation: reset asserted while slot0 is BUSY and slot1 is DONE -> next cycle all outputs are 0; no stale response after deassert; the next request goes to slot 0 with rr_ptr=0.
